// File: rtl/hyper_pkg.sv
// Shared types for the hyper skid register: buffer state encoding and the
// per-state handshake levels that the top module registers onto its ports.
// No logic of its own; imported by hyper_skid_reg.
package hyper_pkg;

    // Occupancy of the 2-entry buffer (output register + skid register).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Downstream valid level that belongs to a given state.
    function automatic logic skid_vld(input skid_state_t st);
        return (st != EMPTY);
    endfunction

    // Upstream ready level that belongs to a given state.
    function automatic logic skid_rdy(input skid_state_t st);
        return (st != FULL);
    endfunction

endpackage

// File: rtl/hyper_skid_reg.sv
// Fully registered 2-entry skid buffer; optional protocol checker under HYPER_SKID_REG_CHECK_EN.
// Latency: 1 cycle from upstream acceptance to o_data when the output register is free.
// Backpressure: o_ready is a flop that drops only when both entries are occupied.
module hyper_skid_reg
    import hyper_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
`ifdef HYPER_SKID_REG_CHECK_EN
    ,
    output logic                  o_err
`endif
);

    skid_state_t           state_q;
    skid_state_t           state_nxt;
    logic                  vld_q;
    logic                  rdy_q;
    logic [DATA_WIDTH-1:0] out_dat_q;
    logic [DATA_WIDTH-1:0] skid_dat_q;

    logic                  up_xfer;
    logic                  dn_xfer;
    logic                  load_out;
    logic                  load_skid;
    logic                  out_from_skid;

    // Handshakes use only the registered ready/valid, so no input reaches an output.
    assign up_xfer = i_valid & rdy_q;
    assign dn_xfer = vld_q & i_ready;

    // Next-state and payload-load decisions for the buffer.
    always_comb begin
        state_nxt     = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    load_out  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                case ({up_xfer, dn_xfer})
                    2'b10: begin
                        // Output register still owed downstream: park the new word.
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end
                    2'b01: begin
                        state_nxt = EMPTY;
                    end
                    2'b11: begin
                        // Pass-through: new word replaces the one just consumed.
                        load_out = 1'b1;
                    end
                    default: begin
                        state_nxt = BUSY;
                    end
                endcase
            end
            FULL: begin
                // rdy_q is low here, so upstream cannot transfer; only drain.
                if (dn_xfer) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_nxt     = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State and handshake flops; ready/valid are precomputed from next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_nxt;
            vld_q   <= skid_vld(state_nxt);
            rdy_q   <= skid_rdy(state_nxt);
        end
    end

    // Payload registers carry no reset so they stay free to retime.
    always_ff @(posedge i_clk) begin
        if (load_out) begin
            out_dat_q <= out_from_skid ? skid_dat_q : i_data;
        end
        if (load_skid) begin
            skid_dat_q <= i_data;
        end
    end

    assign o_data  = out_dat_q;
    assign o_valid = vld_q;
    assign o_ready = rdy_q;

`ifdef HYPER_SKID_REG_CHECK_EN
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] stall_dat_q;
    logic                  err_q;

    // Sticky flag: a stalled offer must be held with the same payload next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= i_valid & ~rdy_q;
            if (stall_q && (!i_valid || (i_data != stall_dat_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    // Snapshot of the offered payload, compared only when the offer stalled.
    always_ff @(posedge i_clk) begin
        stall_dat_q <= i_data;
    end

    assign o_err = err_q;
`endif

endmodule

// File: doc/hyper_skid_reg.md
HYPER_SKID_REG -- requirements
Module: hyper_skid_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, giving the payload width in bits.
REQ-002 SHALL have port i_clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_data, input, DATA_WIDTH bits: upstream payload.
REQ-005 SHALL have port i_valid, input, 1 bit: upstream payload valid.
REQ-006 SHALL have port o_ready, output, 1 bit: registered ready to upstream.
REQ-007 SHALL have port o_data, output, DATA_WIDTH bits: registered payload to downstream.
REQ-008 SHALL have port o_valid, output, 1 bit: registered valid to downstream.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream ready.
REQ-010 SHALL have port o_err, output, 1 bit, present only with the macro in REQ-030: sticky upstream protocol error.

Function
REQ-011 SHALL treat an upstream transfer as i_valid & o_ready, and a downstream transfer as o_valid & i_ready, both sampled at the rising edge of i_clk.
REQ-012 SHALL drive o_data, o_valid and o_ready directly from flops, with no combinational path from any input to any output.
REQ-013 SHALL implement a 2-entry buffer (output register plus skid register) with states EMPTY, BUSY and FULL.
REQ-014 EMPTY SHALL mean o_valid=0 and o_ready=1; on an upstream transfer it SHALL load the output register and go to BUSY.
REQ-015 BUSY SHALL mean o_valid=1 and o_ready=1.
- Upstream only: load the skid register, go to FULL.
- Downstream only: go to EMPTY.
- Both: load the output register with i_data, stay BUSY.
- Neither: hold.
REQ-016 FULL SHALL mean o_valid=1 and o_ready=0; on a downstream transfer it SHALL copy the skid register into the output register and go to BUSY; otherwise it SHALL hold.
REQ-017 SHALL present accepted data on o_data exactly one cycle after acceptance when the block is EMPTY or BUSY with a downstream transfer.
REQ-018 SHALL sustain one transfer per cycle when i_ready is held at 1.
REQ-019 SHALL deliver data in acceptance order, with no loss and no duplication.
REQ-020 SHALL keep o_data stable while o_valid=1 and i_ready=0.
REQ-021 SHALL ignore i_data and i_valid while o_ready=0.

Reset
REQ-022 On i_rst_n=0, SHALL asynchronously force state to EMPTY, o_valid to 0 and o_ready to 1.
REQ-023 SHALL leave the payload registers (output and skid) without reset, so that they are retimable; o_data is undefined until the first transfer.
REQ-024 A reset asserted mid-operation SHALL discard all buffered data; the first cycle after release SHALL behave as EMPTY.
REQ-025 With the macro in REQ-030, reset SHALL clear o_err to 0.

Configuration
REQ-030 Macro HYPER_SKID_REG_CHECK_EN SHALL control the upstream protocol checker.
- When defined: port o_err exists. o_err SHALL set, one cycle after the violation, if i_valid was 1 and o_ready was 0 in a cycle and the next cycle has i_valid=0 or a changed i_data. It SHALL stay set until reset.
- When undefined: no port, no logic, and all other behaviour is identical.

Structure
REQ-031 Package hyper_pkg SHALL hold the typedef enum skid_state_t {EMPTY, BUSY, FULL}.
REQ-032 SHALL be a single module with no sub-module; the enabled payload registers are inferred locally.

Verification
REQ-040 DATA_WIDTH=8, i_ready=1, stream 0x01..0x10 on consecutive cycles -> o_data 0x01..0x10 one cycle later, o_ready constantly 1, no gaps.
REQ-041 Send 0xA5 then 0x5A with i_ready=0 -> state FULL and o_ready=0 in the cycle after 0x5A; raise i_ready -> o_data 0xA5 then 0x5A, o_ready returns to 1.
REQ-042 While FULL, drive i_valid=1 with i_data=0xFF -> 0xFF is never output; o_data holds 0xA5 while i_ready=0.
REQ-043 Alternate i_ready 1/0 every cycle with continuous input 0x00..0x1F -> all 32 values out in order, none lost or duplicated.
REQ-044 Pull i_rst_n low while FULL -> o_valid=0 and o_ready=1 immediately, asynchronously; after release, input 0x3C -> o_data 0x3C next cycle.
REQ-045 With HYPER_SKID_REG_CHECK_EN: hold i_valid=1 while o_ready=0, then change i_data 0x11->0x22 -> o_err=1 the next cycle and stays 1 until reset.
